// File: rtl/spi_slave_mlf.sv
// SPI slave: oversampled by i_clk, single holding register feeding the TX shifter, any SPI mode.
// Define SPI_SLAVE_UNDERRUN_EN to add o_TX_Underrun (pulses when an empty-holding 8'hFF fill occurs).
module spi_slave_mlf #(
  parameter int unsigned SPI_MODE = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_SPI_clk,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO,
  output logic       o_SPI_MISO_En,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_DV
`ifdef SPI_SLAVE_UNDERRUN_EN
  ,
  output logic       o_TX_Underrun
`endif
);

  localparam logic Cpol = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic Cpha = (SPI_MODE == 1) || (SPI_MODE == 3);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e     state_q, state_d;
  logic       sck_meta_q, sck_meta_d, sck_sync_q, sck_sync_d, sck_prev_q, sck_prev_d;
  logic       cs_meta_q, cs_meta_d, cs_sync_q, cs_sync_d, cs_prev_q, cs_prev_d;
  logic       mosi_meta_q, mosi_meta_d, mosi_sync_q, mosi_sync_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [2:0] rx_cnt_q, rx_cnt_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [2:0] tx_cnt_q, tx_cnt_d;
  logic       skip_q, skip_d;
  logic [7:0] hold_q, hold_d;
  logic       tx_ready_q, tx_ready_d;
  logic       rx_done_q, rx_done_d;
  logic       rx_dly_q, rx_dly_d;
  logic       rx_dv_q, rx_dv_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       miso_q, miso_d;
  logic       miso_en_q, miso_en_d;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic       underrun_q, underrun_d;
`endif

  logic lead_edge, trail_edge, sample_edge, drive_edge;
  logic cs_fall, cs_rise, boundary;

  always_comb begin
    sck_meta_d  = i_SPI_clk;
    sck_sync_d  = sck_meta_q;
    sck_prev_d  = sck_sync_q;
    cs_meta_d   = i_SPI_CS_n;
    cs_sync_d   = cs_meta_q;
    cs_prev_d   = cs_sync_q;
    mosi_meta_d = i_SPI_MOSI;
    mosi_sync_d = mosi_meta_q;

    lead_edge   = (sck_prev_q == Cpol) && (sck_sync_q != Cpol);
    trail_edge  = (sck_prev_q != Cpol) && (sck_sync_q == Cpol);
    sample_edge = Cpha ? trail_edge : lead_edge;
    drive_edge  = Cpha ? lead_edge : trail_edge;
    cs_fall     = cs_prev_q & ~cs_sync_q;
    cs_rise     = ~cs_prev_q & cs_sync_q;
  end

  always_comb begin
    state_d    = state_q;
    rx_shift_d = rx_shift_q;
    rx_cnt_d   = rx_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    skip_d     = skip_q;
    hold_d     = hold_q;
    tx_ready_d = tx_ready_q;
    boundary   = 1'b0;
    rx_done_d  = 1'b0;
    // Two extra stages place o_RX_DV four i_clk edges after SCK is first captured.
    rx_dly_d   = rx_done_q;
    rx_dv_d    = rx_dly_q;
    rx_byte_d  = rx_dly_q ? rx_shift_q : rx_byte_q;
`ifdef SPI_SLAVE_UNDERRUN_EN
    underrun_d = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        rx_cnt_d = 3'd7;
        tx_cnt_d = 3'd7;
        skip_d   = 1'b0;
        if (cs_fall) begin
          state_d  = StActive;
          boundary = 1'b1;
          // With CPHA=1 the first leading edge presents the already-loaded MSB.
          skip_d   = Cpha;
        end
      end
      StActive: begin
        if (cs_rise) begin
          state_d    = StIdle;
          rx_cnt_d   = 3'd7;
          tx_cnt_d   = 3'd7;
          skip_d     = 1'b0;
          rx_shift_d = 8'h00;
        end else begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_sync_q};
            rx_cnt_d   = rx_cnt_q - 3'd1;
            if (rx_cnt_q == 3'd0) begin
              rx_done_d = 1'b1;
              boundary  = 1'b1;
              skip_d    = 1'b1;
            end
          end
          if (drive_edge) begin
            if (skip_q) begin
              skip_d = 1'b0;
            end else begin
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
              tx_cnt_d   = tx_cnt_q - 3'd1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (boundary) begin
      tx_cnt_d = 3'd7;
      if (!tx_ready_q) begin
        tx_shift_d = hold_q;
        tx_ready_d = 1'b1;
      end else if (i_TX_DV) begin
        tx_shift_d = i_TX_Byte;
      end else begin
        tx_shift_d = 8'hFF;
`ifdef SPI_SLAVE_UNDERRUN_EN
        underrun_d = 1'b1;
`endif
      end
    end else if (i_TX_DV && tx_ready_q) begin
      hold_d     = i_TX_Byte;
      tx_ready_d = 1'b0;
    end

    miso_en_d = (state_d == StActive);
    miso_d    = (state_d == StActive) ? tx_shift_d[7] : 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      sck_meta_q  <= Cpol;
      sck_sync_q  <= Cpol;
      sck_prev_q  <= Cpol;
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      rx_shift_q  <= 8'h00;
      rx_cnt_q    <= 3'd7;
      tx_shift_q  <= 8'h00;
      tx_cnt_q    <= 3'd7;
      skip_q      <= 1'b0;
      hold_q      <= 8'h00;
      tx_ready_q  <= 1'b1;
      rx_done_q   <= 1'b0;
      rx_dly_q    <= 1'b0;
      rx_dv_q     <= 1'b0;
      rx_byte_q   <= 8'h00;
      miso_q      <= 1'b0;
      miso_en_q   <= 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
      underrun_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sck_meta_q  <= sck_meta_d;
      sck_sync_q  <= sck_sync_d;
      sck_prev_q  <= sck_prev_d;
      cs_meta_q   <= cs_meta_d;
      cs_sync_q   <= cs_sync_d;
      cs_prev_q   <= cs_prev_d;
      mosi_meta_q <= mosi_meta_d;
      mosi_sync_q <= mosi_sync_d;
      rx_shift_q  <= rx_shift_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_shift_q  <= tx_shift_d;
      tx_cnt_q    <= tx_cnt_d;
      skip_q      <= skip_d;
      hold_q      <= hold_d;
      tx_ready_q  <= tx_ready_d;
      rx_done_q   <= rx_done_d;
      rx_dly_q    <= rx_dly_d;
      rx_dv_q     <= rx_dv_d;
      rx_byte_q   <= rx_byte_d;
      miso_q      <= miso_d;
      miso_en_q   <= miso_en_d;
`ifdef SPI_SLAVE_UNDERRUN_EN
      underrun_q  <= underrun_d;
`endif
    end
  end

  assign o_SPI_MISO    = miso_q;
  assign o_SPI_MISO_En = miso_en_q;
  assign o_TX_Ready    = tx_ready_q;
  assign o_RX_Byte     = rx_byte_q;
  assign o_RX_DV       = rx_dv_q;
`ifdef SPI_SLAVE_UNDERRUN_EN
  assign o_TX_Underrun = underrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_mlf.sv
// Directed bench for spi_slave_mlf: one instance per SPI mode, bit-banged master, immediate asserts.
`timescale 1ns/1ps
module tb_spi_slave_mlf;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sck, cs_n, mosi, tx_dv;
  logic [3:0] miso, miso_en, tx_ready, rx_dv;
  logic [7:0] tx_byte [4];
  logic [7:0] rx_byte [4];
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic [3:0] underrun;
  int         und_cnt [4] = '{default: 0};
`endif

  int         n_chk = 0;
  int         n_fail = 0;
  int         dv_cnt [4] = '{default: 0};
  logic [7:0] rx_last [4] = '{default: 8'h00};
  logic [7:0] rx_prev [4] = '{default: 8'h00};
  longint     t_dv [4] = '{default: 0};
  longint     t_smp [4] = '{default: 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_mlf #(.SPI_MODE(g)) u_dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_SPI_clk    (sck[g]),
      .i_SPI_CS_n   (cs_n[g]),
      .i_SPI_MOSI   (mosi[g]),
      .o_SPI_MISO   (miso[g]),
      .o_SPI_MISO_En(miso_en[g]),
      .i_TX_Byte    (tx_byte[g]),
      .i_TX_DV      (tx_dv[g]),
      .o_TX_Ready   (tx_ready[g]),
      .o_RX_Byte    (rx_byte[g]),
      .o_RX_DV      (rx_dv[g])
`ifdef SPI_SLAVE_UNDERRUN_EN
      ,
      .o_TX_Underrun(underrun[g])
`endif
    );
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rx_dv[k]) begin
        dv_cnt[k]++;
        rx_prev[k] = rx_last[k];
        rx_last[k] = rx_byte[k];
        t_dv[k]    = $time;
      end
`ifdef SPI_SLAVE_UNDERRUN_EN
      if (underrun[k]) und_cnt[k]++;
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (6) @(negedge clk);
  endtask

  task automatic load(input int m, input logic [7:0] b);
    @(negedge clk);
    tx_byte[m] = b;
    tx_dv[m]   = 1'b1;
    @(negedge clk);
    tx_dv[m]   = 1'b0;
  endtask

  task automatic wait_ready(input int m);
    int n = 0;
    while (!tx_ready[m] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(tx_ready[m]), 32'd1);
  endtask

  task automatic frame_begin(input int m);
    @(negedge clk);
    cs_n[m] = 1'b0;
    half();
  endtask

  task automatic frame_end(input int m);
    half();
    cs_n[m] = 1'b1;
    half();
  endtask

  // Master side: returns the MISO bits it sampled and whether MISO_En was high at every sample.
  task automatic xfer(input int m, input logic [7:0] mo, input int nbits,
                      output logic [7:0] mi, output logic en_ok);
    logic cpol, cpha;
    cpol  = (m >= 2);
    cpha  = (m == 1) || (m == 3);
    mi    = 8'h00;
    en_ok = 1'b1;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi[m] = mo[i];
        half();
        sck[m]  = ~cpol;
        mi      = {mi[6:0], miso[m]};
        en_ok   = en_ok & miso_en[m];
        t_smp[m] = $time;
        half();
        sck[m]  = cpol;
      end else begin
        sck[m]  = ~cpol;
        mosi[m] = mo[i];
        half();
        sck[m]  = cpol;
        mi      = {mi[6:0], miso[m]};
        en_ok   = en_ok & miso_en[m];
        t_smp[m] = $time;
        half();
      end
    end
  endtask

  logic [7:0] mi0, mi1;
  logic       en0, en1;
  int         d0;

  initial begin
    sck   = 4'b1100;
    cs_n  = 4'hF;
    mosi  = 4'h0;
    tx_dv = 4'h0;
    for (int k = 0; k < 4; k++) tx_byte[k] = 8'h00;

    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k += 3) begin
      chk($sformatf("rst_rx_byte%0d", k), 32'(rx_byte[k]), 32'h00);
      chk($sformatf("rst_rx_dv%0d", k), 32'(rx_dv[k]), 32'd0);
      chk($sformatf("rst_tx_ready%0d", k), 32'(tx_ready[k]), 32'd1);
      chk($sformatf("rst_miso%0d", k), 32'(miso[k]), 32'd0);
      chk($sformatf("rst_miso_en%0d", k), 32'(miso_en[k]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Mode 3 single byte
    load(3, 8'hA5);
    chk("m3_ready_low", 32'(tx_ready[3]), 32'd0);
    d0 = dv_cnt[3];
    frame_begin(3);
    xfer(3, 8'h3C, 8, mi0, en0);
    frame_end(3);
    chk("m3_miso", 32'(mi0), 32'hA5);
    chk("m3_miso_en", 32'(en0), 32'd1);
    chk("m3_dv_count", 32'(dv_cnt[3] - d0), 32'd1);
    chk("m3_rx_byte", 32'(rx_last[3]), 32'h3C);
    chk("m3_dv_latency", 32'(t_dv[3] - t_smp[3]), 32'd50);
    chk("m3_ready_after", 32'(tx_ready[3]), 32'd1);
    chk("m3_en_idle", 32'(miso_en[3]), 32'd0);

    // Mode 0 two-byte frame, second byte loaded once the first is taken
    load(0, 8'h81);
    d0 = dv_cnt[0];
    frame_begin(0);
    wait_ready(0);
    load(0, 8'h7E);
    xfer(0, 8'h12, 8, mi0, en0);
    xfer(0, 8'h34, 8, mi1, en1);
    frame_end(0);
    chk("m0_miso_b0", 32'(mi0), 32'h81);
    chk("m0_miso_b1", 32'(mi1), 32'h7E);
    chk("m0_miso_en", 32'(en0 & en1), 32'd1);
    chk("m0_dv_count", 32'(dv_cnt[0] - d0), 32'd2);
    chk("m0_rx_first", 32'(rx_prev[0]), 32'h12);
    chk("m0_rx_second", 32'(rx_last[0]), 32'h34);
    chk("m0_dv_latency", 32'(t_dv[0] - t_smp[0]), 32'd50);

    // Mode 1 underrun fill
    d0 = dv_cnt[1];
    frame_begin(1);
`ifdef SPI_SLAVE_UNDERRUN_EN
    chk("m1_underrun", 32'(und_cnt[1]), 32'd1);
`endif
    xfer(1, 8'h5A, 8, mi0, en0);
    frame_end(1);
    chk("m1_miso_ff", 32'(mi0), 32'hFF);
    chk("m1_dv_count", 32'(dv_cnt[1] - d0), 32'd1);
    chk("m1_rx_byte", 32'(rx_last[1]), 32'h5A);

    // Aborted frames then a full frame, modes 0 and 3
    for (int m = 0; m < 4; m += 3) begin
      d0 = dv_cnt[m];
      frame_begin(m);
      xfer(m, 8'hF0, 5, mi0, en0);
      frame_end(m);
      chk($sformatf("abort_no_dv%0d", m), 32'(dv_cnt[m] - d0), 32'd0);
      load(m, 8'h96);
      frame_begin(m);
      xfer(m, 8'hC3, 8, mi0, en0);
      frame_end(m);
      chk($sformatf("abort_rx%0d", m), 32'(rx_last[m]), 32'hC3);
      chk($sformatf("abort_dv%0d", m), 32'(dv_cnt[m] - d0), 32'd1);
      chk($sformatf("abort_miso%0d", m), 32'(mi0), 32'h96);
    end

    // Mode 2: second load while full is dropped
    load(2, 8'h11);
    chk("m2_ready_low", 32'(tx_ready[2]), 32'd0);
    load(2, 8'h22);
    chk("m2_ready_still_low", 32'(tx_ready[2]), 32'd0);
    frame_begin(2);
    xfer(2, 8'hE7, 8, mi0, en0);
    frame_end(2);
    chk("m2_miso_kept", 32'(mi0), 32'h11);
    chk("m2_rx_byte", 32'(rx_last[2]), 32'hE7);

    // Mode 3: reset mid-byte
    load(3, 8'h44);
    frame_begin(3);
    xfer(3, 8'hAA, 3, mi0, en0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_rx_byte", 32'(rx_byte[3]), 32'h00);
    chk("mrst_rx_dv", 32'(rx_dv[3]), 32'd0);
    chk("mrst_tx_ready", 32'(tx_ready[3]), 32'd1);
    chk("mrst_miso", 32'(miso[3]), 32'd0);
    chk("mrst_miso_en", 32'(miso_en[3]), 32'd0);
    cs_n[3] = 1'b1;
    sck[3]  = 1'b1;
    mosi[3] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("mrst_idle_en", 32'(miso_en[3]), 32'd0);
    d0 = dv_cnt[3];
    load(3, 8'h69);
    frame_begin(3);
    xfer(3, 8'h96, 8, mi0, en0);
    frame_end(3);
    chk("mrst_miso", 32'(mi0), 32'h69);
    chk("mrst_rx", 32'(rx_last[3]), 32'h96);
    chk("mrst_dv", 32'(dv_cnt[3] - d0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
